// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped byte-stream channels with TX/RX FIFOs,
// plus cycle and retired-instruction counters for the MIPS150 core.
module mmio_io_hub #(
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic                re,
    input  logic [3:0]          we,
    input  logic [31:0]         din,
    output logic [31:0]         dout,
    output logic                hit,
    input  logic                stall,
    input  logic                instr_retire,
    output logic [8*NUM_CH-1:0] tx_data,
    output logic [NUM_CH-1:0]   tx_valid,
    input  logic [NUM_CH-1:0]   tx_ready,
    input  logic [8*NUM_CH-1:0] rx_data,
    input  logic [NUM_CH-1:0]   rx_valid,
    output logic [NUM_CH-1:0]   rx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [7:0]          off;
    logic                rd_v;
    logic                wr_v;
    logic                cnt_clr;
    logic [NUM_CH-1:0]   sel;
    logic [NUM_CH-1:0]   st_rd;
    logic [NUM_CH-1:0]   rx_pop;
    logic [NUM_CH-1:0]   tx_wr;
    logic [NUM_CH-1:0]   tx_full;
    logic [NUM_CH-1:0]   rx_empty;
    logic [NUM_CH-1:0]   tx_ovf;
    logic [8*NUM_CH-1:0] rx_head;
    logic [31:0]         cyc_cnt;
    logic [31:0]         ins_cnt;
    logic [31:0]         rdata;
    logic                unused_din;

    assign unused_din = ^din[31:8];

    assign off     = addr[7:0];
    assign hit     = addr[31:8] == BASE_ADDR[31:8];
    assign rd_v    = hit && !stall && re;
    assign wr_v    = hit && !stall && (we != 4'b0);
    assign cnt_clr = wr_v && off == 8'hF8;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sel[c]    = !off[7] && off[6:4] == 3'(c);
            st_rd[c]  = rd_v && sel[c] && off[3:0] == 4'h0;
            rx_pop[c] = rd_v && sel[c] && off[3:0] == 4'h4 && !rx_empty[c];
            tx_wr[c]  = wr_v && we[0] && sel[c] && off[3:0] == 4'h8;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]    tx_mem [FIFO_DEPTH];
        logic [7:0]    rx_mem [FIFO_DEPTH];
        logic [PW-1:0] tx_rp;
        logic [PW-1:0] tx_wp;
        logic [PW-1:0] rx_rp;
        logic [PW-1:0] rx_wp;
        logic [CW-1:0] tx_cnt;
        logic [CW-1:0] rx_cnt;
        logic          tx_push;
        logic          tx_pop;
        logic          rx_push;
        logic          ovf;

        assign tx_full[c]  = tx_cnt == FULL;
        assign tx_valid[c] = tx_cnt != '0;
        assign rx_empty[c] = rx_cnt == '0;
        assign rx_ready[c] = rx_cnt != FULL;
        assign tx_push     = tx_wr[c] && !tx_full[c];
        assign tx_pop      = tx_valid[c] && tx_ready[c];
        assign rx_push     = rx_valid[c] && rx_ready[c];
        assign tx_ovf[c]   = ovf;
        assign rx_head[8*c +: 8] = rx_mem[rx_rp];
        // Empty FIFO shows 0 so the reset value of tx_data is defined.
        assign tx_data[8*c +: 8] = tx_valid[c] ? tx_mem[tx_rp] : 8'h00;

        always_ff @(posedge clk) begin
            if (tx_push) tx_mem[tx_wp] <= din[7:0];
            if (rx_push) rx_mem[rx_wp] <= rx_data[8*c +: 8];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tx_rp  <= '0;
                tx_wp  <= '0;
                tx_cnt <= '0;
                rx_rp  <= '0;
                rx_wp  <= '0;
                rx_cnt <= '0;
                ovf    <= 1'b0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + 1'b1;
                if (tx_pop)  tx_rp <= tx_rp + 1'b1;
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
                if (rx_push)   rx_wp <= rx_wp + 1'b1;
                if (rx_pop[c]) rx_rp <= rx_rp + 1'b1;
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop[c]);
                // A new overflow beats a clearing STATUS read.
                if (tx_wr[c] && tx_full[c]) ovf <= 1'b1;
                else if (st_rd[c])          ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            off == 8'hF0: rdata = cyc_cnt;
            off == 8'hF4: rdata = ins_cnt;
            default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel[c]) begin
                case (off[3:0])
                    4'h0: rdata = {29'd0, tx_ovf[c], !rx_empty[c], !tx_full[c]};
                    4'h4: rdata = rx_empty[c] ? 32'd0 : {24'd0, rx_head[8*c +: 8]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout    <= '0;
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (rd_v) dout <= rdata;
            if (cnt_clr) begin
                cyc_cnt <= '0;
                ins_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
                if (instr_retire && !stall) ins_cnt <= ins_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed and random stimulus against a queue-level
// reference model, with a separate monitor popping the scoreboard.
module tb_mmio_io_hub;
    localparam int          NCH  = 2;
    localparam int          D    = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      addr = '0;
    logic             re = 1'b0;
    logic [3:0]       we = '0;
    logic [31:0]      din = '0;
    logic [31:0]      dout;
    logic             hit;
    logic             stall = 1'b0;
    logic             instr_retire = 1'b0;
    logic [8*NCH-1:0] tx_data;
    logic [NCH-1:0]   tx_valid;
    logic [NCH-1:0]   tx_ready = '0;
    logic [8*NCH-1:0] rx_data = '0;
    logic [NCH-1:0]   rx_valid = '0;
    logic [NCH-1:0]   rx_ready;

    always #5 clk = ~clk;

    mmio_io_hub #(.NUM_CH(NCH), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .din(din),
        .dout(dout), .hit(hit), .stall(stall), .instr_retire(instr_retire),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    typedef struct packed {
        logic [NCH-1:0] txv;
        logic [NCH-1:0] rxr;
        logic [31:0]    dout;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sent_q [NCH][$];
    logic [7:0] m_tx [NCH][$];
    logic [7:0] m_rx [NCH][$];
    logic [7:0] obs1[$];
    logic [NCH-1:0] m_ovf = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_dout = '0;
    logic [31:0] prev_d = '0;
    bit          have_prev = 0;
    bit          force_wrap = 0;

    logic             u_ret = 1'b0;
    logic [NCH-1:0]   u_txr = '0;
    logic [NCH-1:0]   u_rxv = '0;
    logic [8*NCH-1:0] u_rxd = '0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(logic [7:0] o);
        int c = int'(o[6:4]);
        int r = int'(o[3:0]);
        if (o == 8'hF0) return m_cyc;
        if (o == 8'hF4) return m_ins;
        if (o[7] || c >= NCH) return 32'd0;
        if (r == 0)
            return {29'd0, m_ovf[c], m_rx[c].size() != 0, m_tx[c].size() < D};
        if (r == 4 && m_rx[c].size() != 0) return {24'd0, m_rx[c][0]};
        return 32'd0;
    endfunction

    task automatic step(logic [31:0] a, logic r, logic [3:0] w,
                        logic [31:0] d, logic s);
        exp_t e;
        bit rd, wr, chan, full, rfull, rne;
        int c, rg;
        @(negedge clk);
        rst = 1'b1; addr = a; re = r; we = w; din = d; stall = s;
        instr_retire = u_ret; tx_ready = u_txr;
        rx_valid = u_rxv; rx_data = u_rxd;
        if (force_wrap) begin
            force dut.cyc_cnt = 32'hFFFF_FFFE;
            m_cyc = 32'hFFFF_FFFE;
        end
        rd = a[31:8] == BASE[31:8] && !s && r;
        wr = a[31:8] == BASE[31:8] && !s && w != 4'd0;
        c = int'(a[6:4]);
        rg = int'(a[3:0]);
        chan = !a[7] && c < NCH;
        for (int i = 0; i < NCH; i++) begin
            e.txv[i] = m_tx[i].size() != 0;
            e.rxr[i] = m_rx[i].size() < D;
        end
        if (rd) m_dout = m_read(a[7:0]);
        e.dout = m_dout;
        exp_q.push_back(e);
        if (wr && a[7:0] == 8'hF8) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            m_cyc++;
            if (u_ret && !s) m_ins++;
        end
        for (int i = 0; i < NCH; i++) begin
            full = m_tx[i].size() == D;
            if (u_txr[i] && m_tx[i].size() != 0)
                sent_q[i].push_back(m_tx[i].pop_front());
            if (rd && chan && c == i && rg == 0) m_ovf[i] = 1'b0;
            if (wr && w[0] && chan && c == i && rg == 8) begin
                if (full) m_ovf[i] = 1'b1;
                else m_tx[i].push_back(d[7:0]);
            end
            rfull = m_rx[i].size() == D;
            rne = m_rx[i].size() != 0;
            if (rd && chan && c == i && rg == 4 && rne)
                void'(m_rx[i].pop_front());
            if (u_rxv[i] && !rfull) m_rx[i].push_back(u_rxd[8*i +: 8]);
        end
        if (force_wrap) begin
            #2;
            release dut.cyc_cnt;
            force_wrap = 0;
        end
    endtask

    task automatic idle();
        step(32'h0000_1000, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(logic [7:0] o);
        step(BASE | 32'(o), 1'b1, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic peek(string name, logic [31:0] v);
        @(posedge clk);
        #1;
        chk(name, dout, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; re = 1'b0; we = '0; stall = 1'b0; instr_retire = 1'b0;
        tx_ready = '0; rx_valid = '0; rx_data = '0;
        u_ret = 1'b0; u_txr = '0; u_rxv = '0; u_rxd = '0;
        #1;
        chk("reset dout", dout, 32'd0);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset rx_ready", 32'(rx_ready), 32'({NCH{1'b1}}));
        chk("reset tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            m_tx[i].delete();
            m_rx[i].delete();
            sent_q[i].delete();
        end
        exp_q.delete();
        m_ovf = '0; m_cyc = '0; m_ins = '0; m_dout = '0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                have_prev = 0;
            end else begin
                if (have_prev) chk("dout", dout, prev_d);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL scoreboard: DUT cycle with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_valid", 32'(tx_valid), 32'(e.txv));
                    chk("rx_ready", 32'(rx_ready), 32'(e.rxr));
                    prev_d = e.dout;
                    have_prev = 1;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (tx_valid[i] && tx_ready[i]) begin
                        if (i == 1) obs1.push_back(tx_data[15:8]);
                        if (sent_q[i].size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL tx_unexpected ch%0d: got %h, expected none",
                                     i, tx_data[8*i +: 8]);
                        end else begin
                            chk("tx_data", 32'(tx_data[8*i +: 8]),
                                32'(sent_q[i].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sz;
        logic [31:0] a;
        logic [3:0] w;
        do_reset();

        rd(8'h00);
        peek("status ch0 after reset", 32'h1);

        u_txr = '0;
        for (int i = 0; i < 9; i++)
            step(BASE | 32'h18, 1'b0, 4'h1, 32'h41 + 32'(i), 1'b0);
        rd(8'h10);
        peek("status ch1 overflow", 32'h4);
        rd(8'h10);
        peek("status ch1 cleared", 32'h0);
        obs1.delete();
        u_txr = 2'b10;
        repeat (10) idle();
        u_txr = '0;
        chk("tx ch1 drained count", 32'(obs1.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs1.size(); i++)
            chk("tx ch1 order", 32'(obs1[i]), 32'h41 + 32'(i));

        k = 0;
        u_rxv = 2'b01;
        repeat (10) begin
            u_rxd = {8'h00, 8'(8'h10 + k)};
            sz = m_rx[0].size();
            idle();
            if (m_rx[0].size() > sz) k++;
        end
        u_rxv = '0;
        for (int i = 0; i < 9; i++) begin
            rd(8'h04);
            peek("rxdata ch0", i < 8 ? 32'h10 + 32'(i) : 32'h0);
        end

        u_rxv = 2'b01;
        u_rxd = 16'h00A0;
        idle();
        u_rxd = 16'h00A1;
        idle();
        u_rxv = '0;
        repeat (3) step(BASE | 32'h04, 1'b1, 4'd0, 32'd0, 1'b1);
        rd(8'h04);
        peek("rxdata after stall", 32'hA0);
        rd(8'h04);
        peek("rxdata second", 32'hA1);

        step(BASE | 32'hF8, 1'b0, 4'hF, 32'd0, 1'b0);
        rd(8'hF0);
        peek("cycle after clear", 32'd0);
        rd(8'hF0);
        peek("cycle counting", 32'd1);
        step(BASE | 32'hF8, 1'b0, 4'h2, 32'd0, 1'b0);
        u_ret = 1'b1;
        for (int i = 0; i < 10; i++)
            step(32'h0000_1000, 1'b0, 4'd0, 32'd0, i % 3 == 0);
        u_ret = 1'b0;
        rd(8'hF4);
        peek("instr_cnt", 32'd6);
        rd(8'hF0);
        peek("cycle_cnt", 32'd11);

        force_wrap = 1;
        rd(8'hF0);
        peek("wrap fffffffe", 32'hFFFF_FFFE);
        rd(8'hF0);
        peek("wrap ffffffff", 32'hFFFF_FFFF);
        rd(8'hF0);
        peek("wrap zero", 32'h0);

        for (int i = 0; i < 9; i++)
            step(BASE | 32'h08, 1'b0, 4'h1, 32'h60 + 32'(i), 1'b0);
        u_rxv = 2'b11;
        u_rxd = 16'h5A5A;
        u_txr = 2'b01;
        repeat (3) idle();
        do_reset();
        rd(8'h00);
        peek("status ch0 after mid reset", 32'h1);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            case ($urandom_range(0, 9))
                7: a = BASE | (32'hF0 + 32'(4 * $urandom_range(0, 3)));
                8: a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 63));
                default: a = BASE | 32'(16 * $urandom_range(0, 3)
                                        + 4 * $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 4))
                0: w = 4'h1;
                1: w = 4'hF;
                2: w = 4'h2;
                default: w = 4'h0;
            endcase
            u_txr = NCH'($urandom);
            u_rxv = NCH'($urandom);
            u_rxd = (8*NCH)'($urandom);
            u_ret = 1'($urandom);
            step(a, 1'($urandom), w, $urandom, $urandom_range(0, 7) == 0);
        end
        u_txr = '0;
        u_rxv = '0;
        idle();

        @(posedge clk);
        #1;
        chk("dout final", dout, prev_d);
        for (int i = 0; i < NCH; i++)
            chk("tx bytes pending", 32'(sent_q[i].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
